// File: rtl/alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_ctrl
// Purpose  : Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier
//            controller. Sequences an external shared ALU as its adder, one
//            ADD per cycle for WIDTH cycles.
// Options  : `define MUL_SIGNED_EN adds the signed_op port and a FIX state
//            that negates the product for signed operands of mixed sign.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef MUL_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;
`ifdef MUL_SIGNED_EN
   localparam logic [1:0] c_st_fix  = 2'd3;
`endif

   localparam logic [3:0]       c_alu_add  = 4'b0010;
   localparam logic [3:0]       c_alu_idle = 4'b0000;
   localparam logic [CNT_W-1:0] c_last_it  = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_cap_a;
   logic [WIDTH-1:0] w_cap_b;
`ifdef MUL_SIGNED_EN
   logic             r_fix;   // operation takes the FIX pass
   logic             r_neg;   // result must be negated in FIX
   logic [2*WIDTH-1:0] w_neg_prod;
`endif

   assign product_hi = r_hi;
   assign product_lo = r_lo;

   // Operand capture values: magnitudes for signed requests, raw otherwise
   always_comb begin
      w_cap_a = op_a;
      w_cap_b = op_b;
`ifdef MUL_SIGNED_EN
      if (signed_op) begin
         if (op_a[WIDTH-1]) w_cap_a = ~op_a + 1'b1;
         if (op_b[WIDTH-1]) w_cap_b = ~op_b + 1'b1;
      end
`endif
   end

`ifdef MUL_SIGNED_EN
   assign w_neg_prod = ~{r_hi, r_lo} + 1'b1;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_st_idle;
      else        r_state <= w_next_state;
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (start) w_next_state = c_st_run;
         c_st_run: begin
            if (r_count == c_last_it) begin
`ifdef MUL_SIGNED_EN
               w_next_state = r_fix ? c_st_fix : c_st_done;
`else
               w_next_state = c_st_done;
`endif
            end
         end
`ifdef MUL_SIGNED_EN
         c_st_fix:  w_next_state = c_st_done;
`endif
         c_st_done: w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   // Status flags and ALU drive; the ALU is released whenever not in RUN
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_control = c_alu_idle;
      case (r_state)
         c_st_run: begin
            busy        = 1'b1;
            alu_control = c_alu_add;
            alu_a       = r_hi;
            alu_b       = r_lo[0] ? r_mcand : '0;
         end
`ifdef MUL_SIGNED_EN
         c_st_fix:  busy = 1'b1;
`endif
         c_st_done: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: capture on accepted start, 65-bit shift per RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
`ifdef MUL_SIGNED_EN
         r_fix   <= 1'b0;
         r_neg   <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_mcand <= w_cap_a;
                  r_lo    <= w_cap_b;
                  r_hi    <= '0;
                  r_count <= '0;
`ifdef MUL_SIGNED_EN
                  r_fix   <= signed_op;
                  r_neg   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
               end
            end
            c_st_run: begin
               {r_hi, r_lo} <= {alu_carry, alu_result, r_lo[WIDTH-1:1]};
               r_count      <= r_count + 1'b1;
            end
`ifdef MUL_SIGNED_EN
            c_st_fix: begin
               if (r_neg) {r_hi, r_lo} <= w_neg_prod;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_ctrl
// Purpose  : Self-checking bench for alu_mul_ctrl with a behavioural ALU and
//            an arithmetic product/latency reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] product_hi, product_lo;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_control;
   logic        alu_carry;
`ifdef MUL_SIGNED_EN
   logic        signed_op;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_mul_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef MUL_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .product_hi  (product_hi),
      .product_lo  (product_lo),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry)
   );

   always #5 clk = ~clk;

   // Behavioural alu_32: ADD for 0010, AND for 0000, zero otherwise
   always_comb begin
      {alu_carry, alu_result} = 33'd0;
      if (alu_control == 4'b0010)
         {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      else if (alu_control == 4'b0000)
         alu_result = alu_a & alu_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Run one operation and compare latency, pulse count and product.
   // inj_at > 0 pulses start with other operands during that cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int inj_at, input string tag);
      logic [63:0] exp_p;
      int exp_done, done_cyc, done_cnt, busy_cnt, alu_bad, idle_bad;
      exp_p    = 64'(a) * 64'(b);
      exp_done = 33;
`ifdef MUL_SIGNED_EN
      signed_op = sgn;
      if (sgn) begin
         exp_p    = 64'(longint'($signed(a)) * longint'($signed(b)));
         exp_done = 34;
      end
`else
      if (sgn) exp_p = 64'(a) * 64'(b);
`endif
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; alu_bad = 0; idle_bad = 0;
      start = 1'b1; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c <= 32 && (alu_control != 4'b0010 || (alu_b != 32'd0 && alu_b != dut.r_mcand)))
            alu_bad++;
         if (!busy && (alu_control != 4'b0000 || alu_a != 32'd0 || alu_b != 32'd0))
            idle_bad++;
         if (c == inj_at) begin
            start = 1'b1; op_a = 32'd9; op_b = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
      check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
      check({tag, " alu_run_drive"}, 64'(alu_bad), 64'd0);
      check({tag, " alu_idle_drive"}, 64'(idle_bad), 64'd0);
      check({tag, " product"}, {product_hi, product_lo}, exp_p);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int late_done;
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
`ifdef MUL_SIGNED_EN
      signed_op = 1'b0;
`endif
      // Start asserted with reset: reset must win
      @(posedge clk); #1;
      start = 1'b1; op_a = 32'd5; op_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset product", {product_hi, product_lo}, 64'd0);
      check("reset alu_ctrl", 64'(alu_control), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle after reset busy", 64'(busy), 64'd0);

      run_op(32'd3, 32'd5, 1'b0, 0, "3x5");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "max");
      run_op(32'h12345678, 32'd0, 1'b0, 0, "bzero");
      run_op(32'd0, 32'd7, 1'b0, 0, "azero");
      run_op(32'd2, 32'd2, 1'b0, 10, "ignored_start");

      // Abort mid-operation
      start = 1'b1; op_a = 32'd100; op_b = 32'd50;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort product", {product_hi, product_lo}, 64'd0);
      late_done = 0;
      repeat (40) begin
         if (done || busy) late_done++;
         @(posedge clk); #1;
      end
      check("abort no_activity", 64'(late_done), 64'd0);
      run_op(32'd7, 32'd6, 1'b0, 0, "7x6");

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb, 1'b0, (i % 2 == 0) ? int'($urandom_range(1, 33)) : 0, "rand");
      end

`ifdef MUL_SIGNED_EN
      run_op(32'hFFFFFFFD, 32'd5, 1'b1, 0, "s_neg3x5");
      run_op(32'hFFFFFFFD, 32'd5, 1'b0, 0, "u_neg3x5");
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb, i[0], 0, "srand");
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
